// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-master data RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

  typedef enum logic [1:0] {ST_IDLE, ST_M0, ST_M1, ST_M1_LOCK} state_e;

  localparam int DEF_MAX_WAIT = 4;
  localparam int DEF_MAX_LOCK = 8;

  function automatic int flag_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; width is sized to hold LIMIT.
module arb_sat_counter #(
  parameter int LIMIT = 4,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port data RAM between the core (m0, priority) and a
// secondary req/gnt master (m1) with bounded starvation and bounded locking.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int MAX_LOCK = DEF_MAX_LOCK,
  localparam int FW      = flag_w(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_cen,
  input  logic          m0_wen,
  input  logic [FW-1:0] m0_flag,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_hold,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_wen,
  input  logic [FW-1:0] m1_flag,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          s_cen,
  output logic          s_wen,
  output logic [FW-1:0] s_flag,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(MAX_LOCK + 1);

  state_e              state;
  state_e              state_nxt;
  owner_e              grant;
  owner_e              rd_own;
  owner_e              rd_own_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic                lock_ok;

  // A saturated lock count falls through to the normal priority rules below.
  assign lock_ok = (state == ST_M1_LOCK) && m1_req && (lock_cnt < LOCK_W'(MAX_LOCK));

  always_comb begin
    grant = OWN_NONE;
    if (lock_ok) begin
      grant = OWN_M1;
    end else if (m1_req && (!m0_cen || (wait_cnt == WAIT_W'(MAX_WAIT)))) begin
      grant = OWN_M1;
    end else if (m0_cen) begin
      grant = OWN_M0;
    end
  end

  always_comb begin
    s_cen      = 1'b0;
    s_wen      = 1'b0;
    s_flag     = '0;
    s_addr     = '0;
    s_wdata    = '0;
    state_nxt  = ST_IDLE;
    rd_own_nxt = OWN_NONE;
    case (grant)
      OWN_M0: begin
        s_cen      = 1'b1;
        s_wen      = m0_wen;
        s_flag     = m0_flag;
        s_addr     = m0_addr;
        s_wdata    = m0_wdata;
        state_nxt  = ST_M0;
        rd_own_nxt = m0_wen ? OWN_NONE : OWN_M0;
      end
      OWN_M1: begin
        s_cen      = 1'b1;
        s_wen      = m1_wen;
        s_flag     = m1_flag;
        s_addr     = m1_addr;
        s_wdata    = m1_wdata;
        state_nxt  = m1_lock ? ST_M1_LOCK : ST_M1;
        rd_own_nxt = m1_wen ? OWN_NONE : OWN_M1;
      end
      default: begin
        state_nxt  = ST_IDLE;
        rd_own_nxt = OWN_NONE;
      end
    endcase
  end

  assign m1_gnt    = (grant == OWN_M1);
  assign m0_hold   = m0_cen & (grant != OWN_M0);
  assign m1_rvalid = (rd_own == OWN_M1);
  assign m1_rdata  = s_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rd_own   <= OWN_NONE;
      m0_rdata <= '0;
    end else begin
      state  <= state_nxt;
      rd_own <= rd_own_nxt;
      if (rd_own == OWN_M0) begin
        m0_rdata <= s_rdata;
      end
    end
  end

  arb_sat_counter #(.LIMIT(MAX_WAIT)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (m1_req & ~m1_gnt),
    .clr   (m1_gnt | ~m1_req),
    .count (wait_cnt)
  );

  // Counts grants made under lock; any cycle not ending in M1_LOCK restarts it.
  arb_sat_counter #(.LIMIT(MAX_LOCK)) u_lock_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (m1_gnt & m1_lock),
    .clr   (state_nxt != ST_M1_LOCK),
    .count (lock_cnt)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with hand-computed expectations.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int FW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_cen, m0_wen;
  logic [FW-1:0] m0_flag;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m0_hold;
  logic          m1_req, m1_lock, m1_wen;
  logic [FW-1:0] m1_flag;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          s_cen, s_wen;
  logic [FW-1:0] s_flag;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_cen(m0_cen), .m0_wen(m0_wen), .m0_flag(m0_flag), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_hold(m0_hold),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_wen(m1_wen), .m1_flag(m1_flag),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_cen(s_cen), .s_wen(s_wen), .s_flag(s_flag), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic c0, input logic w0, input logic [AW-1:0] a0,
                               input logic r1, input logic l1, input logic w1,
                               input logic [FW-1:0] f1, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d1);
    m0_cen   = c0;
    m0_wen   = w0;
    m0_flag  = 4'hF;
    m0_addr  = a0;
    m0_wdata = '0;
    m1_req   = r1;
    m1_lock  = l1;
    m1_wen   = w1;
    m1_flag  = f1;
    m1_addr  = a1;
    m1_wdata = d1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(0, 0, '0, 0, 0, 0, '0, '0, '0);
    s_rdata = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #4;
    checkOutput("rst_m0_rdata", m0_rdata, 0);
    checkOutput("rst_m1_rvalid", m1_rvalid, 0);
    checkOutput("rst_m0_hold", m0_hold, 0);
    checkOutput("rst_m1_gnt", m1_gnt, 0);
    checkOutput("rst_s_cen", s_cen, 0);
    checkOutput("rst_state", dut.state, ST_IDLE);

    // m0 read alone
    nextCycle();
    applyStimulus(1, 0, 32'h4000_0010, 0, 0, 0, '0, '0, '0);
    #4;
    checkOutput("m0rd_s_cen", s_cen, 1);
    checkOutput("m0rd_s_wen", s_wen, 0);
    checkOutput("m0rd_s_addr", s_addr, 32'h4000_0010);
    checkOutput("m0rd_s_flag", s_flag, 4'hF);
    checkOutput("m0rd_hold", m0_hold, 0);
    nextCycle();
    applyStimulus(0, 0, '0, 0, 0, 0, '0, '0, '0);
    s_rdata = 32'hDEAD_BEEF;
    #4;
    checkOutput("m0rd_not_yet", m0_rdata, 0);
    checkOutput("m0rd_no_m1_rvalid", m1_rvalid, 0);
    nextCycle();
    s_rdata = 32'h1234_5678;
    #4;
    checkOutput("m0rd_data", m0_rdata, 32'hDEAD_BEEF);
    nextCycle();
    nextCycle();
    #4;
    checkOutput("m0rd_held", m0_rdata, 32'hDEAD_BEEF);

    // m1 read with m0 idle
    nextCycle();
    applyStimulus(0, 0, '0, 1, 0, 0, 4'hF, 32'h4000_0020, '0);
    #4;
    checkOutput("m1rd_gnt", m1_gnt, 1);
    checkOutput("m1rd_s_cen", s_cen, 1);
    checkOutput("m1rd_s_addr", s_addr, 32'h4000_0020);
    checkOutput("m1rd_no_rvalid_yet", m1_rvalid, 0);
    nextCycle();
    applyStimulus(0, 0, '0, 0, 0, 0, '0, '0, '0);
    s_rdata = 32'hCAFE_F00D;
    #4;
    checkOutput("m1rd_rvalid", m1_rvalid, 1);
    checkOutput("m1rd_rdata", m1_rdata, 32'hCAFE_F00D);
    checkOutput("m1rd_m0_rdata_kept", m0_rdata, 32'hDEAD_BEEF);
    nextCycle();
    s_rdata = '0;
    #4;
    checkOutput("m1rd_rvalid_pulse", m1_rvalid, 0);
    checkOutput("m1rd_m0_rdata_after", m0_rdata, 32'hDEAD_BEEF);

    // m1 byte write
    nextCycle();
    applyStimulus(0, 0, '0, 1, 0, 1, 4'b0100, 32'h4000_0000, 32'hA5A5_0000);
    #4;
    checkOutput("m1wr_gnt", m1_gnt, 1);
    checkOutput("m1wr_s_wen", s_wen, 1);
    checkOutput("m1wr_s_flag", s_flag, 4'b0100);
    checkOutput("m1wr_s_wdata", s_wdata, 32'hA5A5_0000);
    checkOutput("m1wr_s_addr", s_addr, 32'h4000_0000);
    nextCycle();
    applyStimulus(0, 0, '0, 0, 0, 0, '0, '0, '0);
    #4;
    checkOutput("m1wr_no_rvalid", m1_rvalid, 0);

    // m1 starved by continuous m0 until wait limit
    for (int c = 0; c < 5; c++) begin
      nextCycle();
      applyStimulus(1, 0, 32'h4000_0100, 1, 0, 0, 4'hF, 32'h4000_0200, '0);
      #4;
      checkOutput($sformatf("starve_gnt_c%0d", c), m1_gnt, (c == 4));
      checkOutput($sformatf("starve_hold_c%0d", c), m0_hold, (c == 4));
    end
    nextCycle();
    applyStimulus(0, 0, '0, 0, 0, 0, '0, '0, '0);
    #4;
    checkOutput("starve_wait_clr", dut.wait_cnt, 0);

    // bounded lock: 4 refused, 8 locked grants, then m0 wins
    nextCycle();
    s_rdata = 32'h9999_0000;
    for (int c = 0; c < 14; c++) begin
      nextCycle();
      applyStimulus(1, 0, 32'h4000_0300, 1, 1, 0, 4'hF, 32'h4000_0400, '0);
      #4;
      checkOutput($sformatf("lock_gnt_c%0d", c), m1_gnt, (c >= 4 && c <= 11));
      checkOutput($sformatf("lock_hold_c%0d", c), m0_hold, (c >= 4 && c <= 11));
    end
    nextCycle();
    applyStimulus(0, 0, '0, 0, 0, 0, '0, '0, '0);
    nextCycle();
    #4;
    checkOutput("pre_rst_m0_rdata", m0_rdata, 32'h9999_0000);

    // reset lands the cycle after an m0 read grant
    nextCycle();
    applyStimulus(1, 0, 32'h4000_0010, 0, 0, 0, '0, '0, '0);
    #4;
    checkOutput("rstrd_s_cen", s_cen, 1);
    nextCycle();
    applyStimulus(0, 0, '0, 0, 0, 0, '0, '0, '0);
    rst = 1'b0;
    s_rdata = 32'h1111_2222;
    nextCycle();
    rst = 1'b1;
    #4;
    checkOutput("rstrd_m0_rdata", m0_rdata, 0);
    checkOutput("rstrd_m1_rvalid", m1_rvalid, 0);
    checkOutput("rstrd_state", dut.state, ST_IDLE);
    nextCycle();
    #4;
    checkOutput("rstrd_m0_rdata_stays", m0_rdata, 0);

    // fresh m0 read after reset
    nextCycle();
    applyStimulus(1, 0, 32'h4000_0030, 0, 0, 0, '0, '0, '0);
    #4;
    checkOutput("fresh_s_cen", s_cen, 1);
    checkOutput("fresh_hold", m0_hold, 0);
    nextCycle();
    applyStimulus(0, 0, '0, 0, 0, 0, '0, '0, '0);
    s_rdata = 32'h0BAD_F00D;
    nextCycle();
    s_rdata = '0;
    #4;
    checkOutput("fresh_m0_rdata", m0_rdata, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
